// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types and constants for the data_cache slice.
//                Holds the controller state encoding, default geometry and
//                helpers that derive address-field widths from geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    localparam int c_DEF_LINE_NUM       = 16;
    localparam int c_DEF_WORDS_PER_LINE = 4;
    localparam int c_DEF_MEM_DELAY      = 50;

    // Width of the line index field
    function automatic int index_bits(input int line_num);
        return $clog2(line_num);
    endfunction

    // Width of the word-within-line field
    function automatic int word_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Tag width: the 30-bit word address minus index and word fields
    function automatic int tag_bits(input int line_num, input int words_per_line);
        return 30 - $clog2(line_num) - $clog2(words_per_line);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_backing_mem.sv
`default_nettype none
// ============================================================================
//  Module      : cache_backing_mem
//  Description : Backing store behind data_cache, organised as whole lines.
//                Zero at time 0 and never cleared by reset.
//  Ports       : clk        - clock, rising edge
//                i_wr_en    - write the whole line i_wr_data at i_wr_line
//                i_wr_line  - line number for the write port
//                i_wr_data  - line-wide write data
//                i_rd_line  - line number for the combinational read port
//                o_rd_data  - line-wide read data
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_backing_mem
    import cache_pkg::*;
#(
    parameter int WORDS_PER_LINE = c_DEF_WORDS_PER_LINE,
    parameter int MEM_WORDS      = 16384,
    parameter int LINE_AW        = $clog2(MEM_WORDS / WORDS_PER_LINE)
) (
    input  logic                           clk,
    input  logic                           i_wr_en,
    input  logic [LINE_AW-1:0]             i_wr_line,
    input  logic [WORDS_PER_LINE-1:0][31:0] i_wr_data,
    input  logic [LINE_AW-1:0]             i_rd_line,
    output logic [WORDS_PER_LINE-1:0][31:0] o_rd_data
);

    localparam int c_LINES = MEM_WORDS / WORDS_PER_LINE;

    // Storage keeps its contents across reset; only power-up zeroes it.
    logic [WORDS_PER_LINE-1:0][31:0] r_mem [c_LINES] = '{default: '0};

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_line] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_line];

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
//  Module      : data_cache
//  Description : Direct-mapped, write-back, write-allocate data cache with a
//                valid/ready request handshake and a one-cycle response pulse.
//                Misses access a fixed-latency backing memory (MEM_DELAY
//                cycles per line transfer) before responding.
//  Ports       : clk, reset (async, active-low)
//                is_input_valid, addr, mem_read, mem_write, din - request
//                is_ready        - idle, request may be accepted
//                is_output_valid - one-cycle response pulse
//                dout, is_hit    - response data / first-lookup hit flag
//                hit_count, miss_count - response counters (CACHE_STATS_EN)
//  Options     : define CACHE_STATS_EN to add the hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_cache
    import cache_pkg::*;
#(
    parameter int LINE_NUM       = c_DEF_LINE_NUM,
    parameter int WORDS_PER_LINE = c_DEF_WORDS_PER_LINE,
    parameter int MEM_DELAY      = c_DEF_MEM_DELAY,
    parameter int MEM_WORDS      = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_input_valid,
    input  logic [31:0] addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] din,
    output logic        is_ready,
    output logic        is_output_valid,
    output logic [31:0] dout,
    output logic        is_hit
`ifdef CACHE_STATS_EN
   ,output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int c_IDX_W   = index_bits(LINE_NUM);
    localparam int c_WORD_W  = word_bits(WORDS_PER_LINE);
    localparam int c_TAG_W   = tag_bits(LINE_NUM, WORDS_PER_LINE);
    localparam int c_LINE_AW = $clog2(MEM_WORDS / WORDS_PER_LINE);
    localparam int c_CNT_W   = $clog2(MEM_DELAY + 1);
    localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(MEM_DELAY - 1);

    state_t                          r_state;
    logic [29:0]                     r_addr;      // word address of the request
    logic [31:0]                     r_din;
    logic                            r_is_write;
    logic                            r_miss_seen;
    logic [c_CNT_W-1:0]              r_count;
    logic [31:0]                     r_dout;
    logic                            r_out_valid;
    logic                            r_hit;
    logic [LINE_NUM-1:0]             r_valid;
    logic [LINE_NUM-1:0]             r_dirty;
    logic [c_TAG_W-1:0]              r_tag  [LINE_NUM];
    logic [WORDS_PER_LINE-1:0][31:0] r_data [LINE_NUM];
`ifdef CACHE_STATS_EN
    logic [31:0]                     r_hit_count;
    logic [31:0]                     r_miss_count;
`endif

    logic [c_WORD_W-1:0]             w_word;
    logic [c_IDX_W-1:0]              w_idx;
    logic [c_TAG_W-1:0]              w_tag;
    logic                            w_hit;
    logic                            w_count_zero;
    logic                            w_wb_done;
    logic                            w_fill_done;
    logic                            w_wr_hit;
    logic [c_LINE_AW-1:0]            w_victim_line;
    logic [c_LINE_AW-1:0]            w_fill_line;
    logic [WORDS_PER_LINE-1:0][31:0] w_mem_rd;
    logic                            w_unused;

    assign w_word       = r_addr[c_WORD_W-1:0];
    assign w_idx        = r_addr[c_WORD_W +: c_IDX_W];
    assign w_tag        = r_addr[29 -: c_TAG_W];
    assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_count_zero = (r_count == '0);
    assign w_wb_done    = (r_state == WRITEBACK) && w_count_zero;
    assign w_fill_done  = (r_state == FILL) && w_count_zero;
    assign w_wr_hit     = (r_state == COMPARE) && w_hit && r_is_write;

    // Backing memory is addressed by line number; only the low tag bits are
    // needed because the backing store is smaller than the address space.
    assign w_victim_line = {r_tag[w_idx][c_LINE_AW-c_IDX_W-1:0], w_idx};
    assign w_fill_line   = r_addr[c_WORD_W +: c_LINE_AW];

    // Byte offset within a word is don't-care
    assign w_unused = ^addr[1:0];

    assign is_ready        = (r_state == IDLE);
    assign is_output_valid = r_out_valid;
    assign dout            = r_dout;
    assign is_hit          = r_hit;
`ifdef CACHE_STATS_EN
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

    cache_backing_mem #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .MEM_WORDS      (MEM_WORDS),
        .LINE_AW        (c_LINE_AW)
    ) u_backing_mem (
        .clk       (clk),
        .i_wr_en   (w_wb_done),
        .i_wr_line (w_victim_line),
        .i_wr_data (r_data[w_idx]),
        .i_rd_line (w_fill_line),
        .o_rd_data (w_mem_rd)
    );

    // Line payload and tags need no reset: valid bits gate their use.
    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            r_data[w_idx] <= w_mem_rd;
            r_tag[w_idx]  <= w_tag;
        end else if (w_wr_hit) begin
            r_data[w_idx][w_word] <= r_din;
        end
    end

    // Controller: request latch, delay counter, line status and response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_din        <= '0;
            r_is_write   <= 1'b0;
            r_miss_seen  <= 1'b0;
            r_count      <= '0;
            r_dout       <= '0;
            r_out_valid  <= 1'b0;
            r_hit        <= 1'b0;
            r_valid      <= '0;
            r_dirty      <= '0;
`ifdef CACHE_STATS_EN
            r_hit_count  <= '0;
            r_miss_count <= '0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (is_input_valid && (mem_read || mem_write)) begin
                        r_addr     <= addr[31:2];
                        r_din      <= din;
                        r_is_write <= mem_write;
                        r_state    <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (w_hit) begin
                        if (r_is_write) begin
                            r_dirty[w_idx] <= 1'b1;
                        end else begin
                            r_dout <= r_data[w_idx][w_word];
                        end
                        r_out_valid <= 1'b1;
                        r_hit       <= !r_miss_seen;
                        r_miss_seen <= 1'b0;
                        r_state     <= IDLE;
`ifdef CACHE_STATS_EN
                        if (r_miss_seen) begin
                            r_miss_count <= r_miss_count + 32'd1;
                        end else begin
                            r_hit_count  <= r_hit_count + 32'd1;
                        end
`endif
                    end else begin
                        r_miss_seen <= 1'b1;
                        r_count     <= c_RELOAD;
                        r_state     <= (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (w_count_zero) begin
                        r_count <= c_RELOAD;
                        r_state <= FILL;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                FILL: begin
                    if (w_count_zero) begin
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= COMPARE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_cache
//  Description : Self-checking bench for data_cache. An architectural model
//                (flat memory image, backing image, per-index residency)
//                predicts latency, dout and is_hit; a compare process checks
//                the DUT outputs every cycle, and literal expectations pin
//                the model on the directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache;

    localparam int c_D = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        is_input_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    wire         is_ready;
    wire         is_output_valid;
    wire  [31:0] dout;
    wire         is_hit;
`ifdef CACHE_STATS_EN
    wire  [31:0] hit_count;
    wire  [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    data_cache #(
        .LINE_NUM       (16),
        .WORDS_PER_LINE (4),
        .MEM_DELAY      (c_D),
        .MEM_WORDS      (16384)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (is_input_valid),
        .addr            (addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .din             (din),
        .is_ready        (is_ready),
        .is_output_valid (is_output_valid),
        .dout            (dout),
        .is_hit          (is_hit)
`ifdef CACHE_STATS_EN
       ,.hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          pending = 1'b0;
    int          due = 0;
    int          acc = 0;
    int          last_resp = 0;
    logic [31:0] exp_dout = '0;
    logic        exp_hit = 1'b0;
    logic [31:0] last_dout = '0;
    logic        last_hit = 1'b0;

    // Architectural model
    logic [31:0] shadow [16384];   // value a read must return
    logic [31:0] bmem   [16384];   // backing memory contents
    bit          mvalid [16];
    bit          mdirty [16];
    logic [23:0] mtag   [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model's expected response schedule
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (pending && cyc < due) begin
                chk("busy_valid", is_output_valid, 0);
                chk("busy_ready", is_ready, 0);
            end else if (pending && cyc == due) begin
                chk("resp_valid", is_output_valid, 1);
                chk("resp_ready", is_ready, 1);
                chk("resp_dout", dout, exp_dout);
                chk("resp_hit", is_hit, exp_hit);
                last_dout = exp_dout;
                last_hit  = exp_hit;
                pending   = 1'b0;
            end else begin
                chk("idle_valid", is_output_valid, 0);
                chk("idle_ready", is_ready, 1);
                chk("hold_dout", dout, last_dout);
                chk("hold_hit", is_hit, last_hit);
            end
            if (is_output_valid) last_resp = cyc;
        end
    end

    // Apply the request to the model, then present it for one accept edge
    task automatic start_req(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, input bit hold);
        int idx, w, lat, vbase;
        bit hit;
        @(negedge clk);
        idx = int'(a[7:4]);
        w   = int'(a[15:2]);
        hit = mvalid[idx] && (mtag[idx] == a[31:8]);
        if (hit) begin
            lat = 2;
        end else begin
            if (mvalid[idx] && mdirty[idx]) begin
                lat   = 3 + 2 * c_D;
                vbase = ((int'(mtag[idx]) * 16 + idx) * 4) % 16384;
                for (int k = 0; k < 4; k++) bmem[vbase + k] = shadow[vbase + k];
            end else begin
                lat = 3 + c_D;
            end
            mvalid[idx] = 1'b1;
            mdirty[idx] = 1'b0;
            mtag[idx]   = a[31:8];
        end
        if (wr) begin
            shadow[w]   = d;
            mdirty[idx] = 1'b1;
            exp_dout    = last_dout;
        end else begin
            exp_dout = shadow[w];
        end
        exp_hit = hit;
        due     = cyc + lat;
        acc     = cyc + 1;
        pending = 1'b1;
        is_input_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        addr = a;
        din  = d;
        @(negedge clk);
        if (!hold) begin
            is_input_valid = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    task automatic wait_resp();
        for (int k = 0; k < 3 * c_D && pending; k++) @(negedge clk);
        if (pending) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: no response by cycle %0d (due %0d)", cyc, due);
            pending = 1'b0;
        end
        is_input_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit hold);
        start_req(rd, wr, a, d, hold);
        wait_resp();
    endtask

    // Hand-computed expectations for the last response
    task automatic lit(input string name, input logic [31:0] e_dout,
                       input logic e_hit, input int e_lat);
        chk({name, "_dout"}, dout, e_dout);
        chk({name, "_hit"}, is_hit, e_hit);
        chk({name, "_lat"}, last_resp - acc + 1, e_lat);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", is_ready, 1);
        chk("rst_valid", is_output_valid, 0);
        chk("rst_dout", dout, 0);
        pending   = 1'b0;
        last_dout = '0;
        last_hit  = 1'b0;
        // Dirty lines are lost: their words revert to backing contents
        for (int i = 0; i < 16; i++) begin
            if (mvalid[i] && mdirty[i]) begin
                int vb;
                vb = ((int'(mtag[i]) * 16 + i) * 4) % 16384;
                for (int k = 0; k < 4; k++) shadow[vb + k] = bmem[vb + k];
            end
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            shadow[i] = '0;
            bmem[i]   = '0;
        end
        for (int i = 0; i < 16; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
            mtag[i]   = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Cold read miss, then hit
        req(1, 0, 32'h100, 0, 0);              lit("t1_miss", 32'h0, 0, 53);
        req(1, 0, 32'h100, 0, 0);              lit("t1_hit", 32'h0, 1, 2);
`ifdef CACHE_STATS_EN
        chk("stats_hit1", hit_count, 1);
        chk("stats_miss1", miss_count, 1);
`endif
        // Write hit, read back
        req(0, 1, 32'h104, 32'hDEADBEEF, 0);   lit("t2_wr", 32'h0, 1, 2);
        req(1, 0, 32'h104, 0, 0);              lit("t2_rd", 32'hDEADBEEF, 1, 2);
        // Dirty eviction, round trip through backing memory
        req(0, 1, 32'h200, 32'h11, 0);         lit("t3_wr", 32'hDEADBEEF, 0, 103);
        req(1, 0, 32'h104, 0, 0);              lit("t3_rd104", 32'hDEADBEEF, 0, 103);
        req(1, 0, 32'h200, 0, 0);              lit("t3_rd200", 32'h11, 0, 53);
        // Dirty the line, then reset during an unrelated fill
        req(0, 1, 32'h200, 32'h22, 0);         lit("t4_wr", 32'h11, 1, 2);
        start_req(1, 0, 32'h1040, 0, 0);
        repeat (10) @(negedge clk);
        do_reset();
`ifdef CACHE_STATS_EN
        chk("stats_hit_rst", hit_count, 0);
        chk("stats_miss_rst", miss_count, 0);
`endif
        req(1, 0, 32'h1040, 0, 0);             lit("t4_reread", 32'h0, 0, 53);
        req(1, 0, 32'h200, 0, 0);              lit("t4_lost", 32'h11, 0, 53);
        req(1, 0, 32'h104, 0, 0);              lit("t4_kept", 32'hDEADBEEF, 0, 53);
        // Request valid held through a miss: one response only
        req(1, 0, 32'h3000, 0, 1);             lit("t5_hold", 32'h0, 0, 53);
        // No op bits: ignored
        @(negedge clk);
        is_input_valid = 1'b1;
        addr = 32'h100;
        repeat (3) begin
            @(negedge clk);
            chk("t5_noop_ready", is_ready, 1);
        end
        is_input_valid = 1'b0;
        // Both op bits: write
        req(1, 1, 32'h3004, 32'hCAFEF00D, 0);  lit("t5_both", 32'h0, 1, 2);
        req(1, 0, 32'h3004, 0, 0);             lit("t5_both_rd", 32'hCAFEF00D, 1, 2);
        req(1, 0, 32'h3000, 0, 0);             lit("t5_word0", 32'h0, 1, 2);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_cache.md
# data_cache

Single-port, direct-mapped, write-back, write-allocate data cache that responds to CPU memory requests through a valid/ready handshake. It replaces the single-cycle data memory behind the MEM stage: the pipeline initiates a request and stalls until this block returns a response. On a miss, a fixed-latency backing memory is accessed internally before the response is sent.

## Interface
- LINE_NUM, 16, number of cache lines (power of 2)
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2)
- MEM_DELAY, 50, backing-memory cycles per line read or line write (≥1)
- MEM_WORDS, 16384, backing-memory size in words
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- is_input_valid  input  1  request valid
- addr  input  32  byte address; addr[1:0] ignored
- mem_read  input  1  read request
- mem_write  input  1  write request; takes precedence over mem_read
- din  input  32  write data
- is_ready  output  1  idle; a request may be accepted
- is_output_valid  output  1  one-cycle response pulse
- dout  output  32  read data, valid when is_output_valid=1
- is_hit  output  1  the response hit on first lookup

## Operation
- Address split at the defaults: tag=addr[31:8], index=addr[7:4], word=addr[3:2]. The general case is log2(LINE_NUM) index bits and log2(WORDS_PER_LINE) word bits.
- Per line, the block keeps valid, dirty, tag, and data words.
- A request is accepted on a rising edge when is_input_valid=1, is_ready=1, and (mem_read|mem_write)=1. At acceptance, addr, din, and op are latched.
  - A request with is_input_valid=1 but both mem_read and mem_write low is ignored: no state change, no response.
  - Inputs are ignored while is_ready=0.
- State machine:
  - IDLE: is_ready=1. On accept, go to COMPARE.
  - COMPARE:
    - Hit: on a read, register dout from the line word; on a write, update the word and set dirty. Register is_output_valid=1 and is_hit=!miss_seen, clear miss_seen, and go to IDLE.
    - Miss, clean or invalid line: set miss_seen, load the counter with MEM_DELAY-1, and go to FILL.
    - Miss, dirty line: set miss_seen, load the counter, and go to WRITEBACK.
  - WRITEBACK: decrement the counter each cycle. At 0, write the whole victim line to backing memory, reload the counter, and go to FILL.
  - FILL: decrement the counter each cycle. At 0, read the line from backing memory and set valid=1, dirty=0, and tag=latched tag. Go to COMPARE, which now hits.
- Writebacks and fills are atomic. Backing memory changes only at the counter-zero edge.
- A write miss allocates the line, then merges din in the following COMPARE.

## Timing
- Request accepted at the end of cycle N.
- Response visibility:
  - Hit: response visible in cycle N+2.
  - Clean miss: response visible in cycle N+3+MEM_DELAY.
  - Dirty miss: response visible in cycle N+3+2·MEM_DELAY.
- is_output_valid is high for exactly one cycle, the same cycle in which is_ready returns to 1. A new request may be accepted at the end of that cycle, so back-to-back hits sustain one access every 2 cycles.
- dout and is_hit hold their values until the next response. dout is unchanged on a write response.
- is_ready is decoded combinationally from state (IDLE).
- Reset values: state=IDLE, is_ready=1, is_output_valid=0, dout=0, is_hit=0, all valid=0 and dirty=0, counter=0, miss_seen=0.
- Reset asserted mid-operation (any state) takes effect immediately:
  - Pending request and dirty data are discarded.
  - Backing memory is not modified by the reset.
  - No response is issued for the aborted request.
- Backing memory is zero-initialized at time 0 and is not cleared by reset.

## Configuration
- CACHE_STATS_EN defined: adds output ports hit_count [31:0] and miss_count [31:0].
  - On each response, exactly one of the two counters increments, per is_hit.
  - Both counters are cleared by reset and wrap at 2^32.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Package cache_pkg holds:
  - state enum (IDLE, COMPARE, WRITEBACK, FILL)
  - default LINE_NUM, WORDS_PER_LINE, and MEM_DELAY constants
  - derived index/word/tag width functions
- Sub-module cache_backing_mem holds the MEM_WORDS array. It has a line-wide write port and a line-wide combinational read port, both addressed by line number.
- The delay counter and the state machine remain in data_cache.

## Test plan
1. **Cold read miss then hit.** Reset, then read 0x100 (MEM_DELAY=50): response at N+53 with dout=0 and is_hit=0. Repeat the read: response at N+2 with is_hit=1.
2. **Write hit then read back.** Write 0xDEADBEEF to 0x104 (line present): response at N+2 with is_hit=1. Read 0x104: dout=0xDEADBEEF, is_hit=1.
3. **Dirty eviction.** After test 2, write 0x11 to 0x200 (same index 0): response at N+103, is_hit=0. Read 0x104: response at N+103, dout=0xDEADBEEF. Read 0x200: dout=0x11.
4. **Reset during fill.** Pull reset low 10 cycles into a FILL: is_ready=1, is_output_valid=0, and dout=0 immediately. Re-read the same address: is_hit=0.
5. **Ignored requests.**
   - is_input_valid held high during a miss: exactly one response.
   - Request with mem_read=mem_write=0: no response, is_ready stays 1.
   - Both op bits high: performed as a write.
6. **Stats (CACHE_STATS_EN).** After test 1: hit_count=1, miss_count=1. After reset: both counters 0.
